// File: rtl/mem_stage_lsu_pkg.sv
// Shared RV32I memory-stage definitions: funct3 encodings, LSU FSM states,
// and access-size decoding.
package mem_stage_lsu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RV} lsu_state_e;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} lsu_size_e;

    // Anything that is not a recognised byte/half encoding is a word access.
    function automatic lsu_size_e f3_size(input logic [2:0] f3, input logic is_store);
        lsu_size_e sz;
        sz = SZ_WORD;
        if (is_store) begin
            case (f3)
                F3_SB:   sz = SZ_BYTE;
                F3_SH:   sz = SZ_HALF;
                F3_SW:   sz = SZ_WORD;
                default: sz = SZ_WORD;
            endcase
        end else begin
            case (f3)
                F3_LB, F3_LBU: sz = SZ_BYTE;
                F3_LH, F3_LHU: sz = SZ_HALF;
                F3_LW:         sz = SZ_WORD;
                default:       sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational lane logic: store byte-enable/data steering, load byte/half
// extraction with sign/zero extension, and misalignment detection.
module mem_stage_lsu_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lanes,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [7:0]  rbyte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic        zext;
    lsu_size_e   size;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rbyte[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        size        = f3_size(funct3, is_store);
        zext        = !is_store && (funct3 == F3_LBU || funct3 == F3_LHU);
        sel_byte    = rbyte[addr_lo];
        sel_half    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        be          = 4'b1111;
        wdata_lanes = wdata;
        load_data   = rdata;
        misalign    = |addr_lo;
        case (size)
            SZ_BYTE: begin
                be          = 4'b0001 << addr_lo;
                wdata_lanes = {4{wdata[7:0]}};
                load_data   = {{24{!zext & sel_byte[7]}}, sel_byte};
                misalign    = 1'b0;
            end
            SZ_HALF: begin
                be          = 4'b0011 << addr_lo;
                wdata_lanes = {2{wdata[15:0]}};
                load_data   = {{16{!zext & sel_half[15]}}, sel_half};
                misalign    = addr_lo[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// RV32I memory stage: EX/MEM and MEM/WB registers plus a req/gnt/rvalid
// load/store unit that stalls the pipeline while an access is outstanding.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] alu_data_E,
    input  logic [WIDTH-1:0] write_data_E,
    input  logic [4:0]       rd_E,
    input  logic             reg_write_E,
    input  logic             mem_read_E,
    input  logic             mem_write_E,
    input  logic [2:0]       funct3_E,
    output logic [WIDTH-1:0] alu_data_M,
    output logic [4:0]       rd_M,
    output logic             reg_write_M,
    output logic             stall_M,
    output logic             misalign_M,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [WIDTH-1:0] mem_addr_o,
    output logic [3:0]       mem_be_o,
    output logic [WIDTH-1:0] mem_wdata_o,
    input  logic             mem_gnt_i,
    input  logic             mem_rvalid_i,
    input  logic [WIDTH-1:0] mem_rdata_i,
    output logic [4:0]       rd_W,
    output logic             reg_write_W,
    output logic             mem_to_reg_W,
    output logic [WIDTH-1:0] alu_data_W,
    output logic [WIDTH-1:0] load_data_W
);

    logic [WIDTH-1:0] write_data_M;
    logic             mem_read_M;
    logic             mem_write_M;
    logic [2:0]       funct3_M;
    lsu_state_e       state_reg;

    logic [3:0]       be;
    logic [WIDTH-1:0] wdata_lanes;
    logic [WIDTH-1:0] load_data;
    logic             misalign;
    logic             mem_op_M;
    logic             gnt_ok;
    logic             done;

    mem_stage_lsu_align u_align (
        .addr_lo     (alu_data_M[1:0]),
        .funct3      (funct3_M),
        .is_store    (mem_write_M),
        .wdata       (write_data_M),
        .rdata       (mem_rdata_i),
        .be          (be),
        .wdata_lanes (wdata_lanes),
        .load_data   (load_data),
        .misalign    (misalign)
    );

    // A misaligned access never reaches the bus; it simply retires without write-back.
    assign misalign_M  = (mem_read_M | mem_write_M) & misalign;
    assign mem_op_M    = (mem_read_M | mem_write_M) & !misalign;
    assign mem_req_o   = mem_op_M & (state_reg != WAIT_RV);
    assign gnt_ok      = mem_req_o & mem_gnt_i;
    assign done        = (gnt_ok & mem_write_M) | ((state_reg == WAIT_RV) & mem_rvalid_i);
    assign stall_M     = mem_op_M & !done;
    assign mem_we_o    = mem_op_M & mem_write_M;
    assign mem_addr_o  = {alu_data_M[WIDTH-1:2], 2'b00};
    assign mem_be_o    = mem_op_M ? be : 4'b0000;
    assign mem_wdata_o = (mem_op_M & mem_write_M) ? wdata_lanes : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE, WAIT_GNT: begin
                    if (mem_op_M) begin
                        if (gnt_ok) state_reg <= mem_write_M ? IDLE : WAIT_RV;
                        else        state_reg <= WAIT_GNT;
                    end
                end
                WAIT_RV: if (mem_rvalid_i) state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alu_data_M   <= '0;
            write_data_M <= '0;
            rd_M         <= '0;
            reg_write_M  <= 1'b0;
            mem_read_M   <= 1'b0;
            mem_write_M  <= 1'b0;
            funct3_M     <= '0;
        end else if (!stall_M) begin
            alu_data_M   <= alu_data_E;
            write_data_M <= write_data_E;
            rd_M         <= rd_E;
            reg_write_M  <= reg_write_E;
            mem_read_M   <= mem_read_E;
            mem_write_M  <= mem_write_E;
            funct3_M     <= funct3_E;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_W         <= '0;
            reg_write_W  <= 1'b0;
            mem_to_reg_W <= 1'b0;
            alu_data_W   <= '0;
            load_data_W  <= '0;
        end else if (stall_M) begin
            reg_write_W  <= 1'b0;
            mem_to_reg_W <= 1'b0;
        end else begin
            rd_W         <= rd_M;
            reg_write_W  <= reg_write_M & !misalign_M;
            mem_to_reg_W <= mem_read_M & !misalign_M;
            alu_data_W   <= alu_data_M;
            load_data_W  <= (mem_op_M & mem_read_M) ? load_data : '0;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed-vector bench for the memory stage: stores, loads with wait states,
// misalignment, reset during an access, and stall/bubble behaviour.
module tb_mem_stage_lsu;
    import mem_stage_lsu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] alu_data_E, write_data_E;
    logic [4:0]  rd_E;
    logic        reg_write_E, mem_read_E, mem_write_E;
    logic [2:0]  funct3_E;
    logic [31:0] alu_data_M;
    logic [4:0]  rd_M;
    logic        reg_write_M, stall_M, misalign_M;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic [4:0]  rd_W;
    logic        reg_write_W, mem_to_reg_W;
    logic [31:0] alu_data_W, load_data_W;

    int vectors = 0;
    int miscompares = 0;

    mem_stage_lsu #(.WIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .alu_data_E(alu_data_E), .write_data_E(write_data_E), .rd_E(rd_E),
        .reg_write_E(reg_write_E), .mem_read_E(mem_read_E), .mem_write_E(mem_write_E),
        .funct3_E(funct3_E),
        .alu_data_M(alu_data_M), .rd_M(rd_M), .reg_write_M(reg_write_M),
        .stall_M(stall_M), .misalign_M(misalign_M),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .rd_W(rd_W), .reg_write_W(reg_write_W), .mem_to_reg_W(mem_to_reg_W),
        .alu_data_W(alu_data_W), .load_data_W(load_data_W)
    );

    always #5 clk_i = ~clk_i;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ex_nop();
        alu_data_E = '0; write_data_E = '0; rd_E = '0;
        reg_write_E = 1'b0; mem_read_E = 1'b0; mem_write_E = 1'b0; funct3_E = '0;
    endtask

    task automatic ex_store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
        ex_nop();
        alu_data_E = addr; write_data_E = data; mem_write_E = 1'b1; funct3_E = f3;
    endtask

    task automatic ex_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd);
        ex_nop();
        alu_data_E = addr; mem_read_E = 1'b1; reg_write_E = 1'b1; rd_E = rd; funct3_E = f3;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        ex_nop();
        step(); step();
        rst_i = 1'b0;
        #2;
        vectors++; if (mem_req_o !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b exp 0", mem_req_o); end
        vectors++; if (stall_M !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %b exp 0", stall_M); end
        vectors++; if (reg_write_W !== 1'b0 || mem_to_reg_W !== 1'b0) begin miscompares++; $display("FAIL reset_w_ctl got %b%b exp 00", reg_write_W, mem_to_reg_W); end
        vectors++; if (mem_be_o !== 4'b0 || mem_addr_o !== 32'h0 || alu_data_M !== 32'h0) begin miscompares++; $display("FAIL reset_data got be %h addr %h alu %h exp 0", mem_be_o, mem_addr_o, alu_data_M); end
        $display("reset: outputs checked after synchronous reset");
    endtask

    task automatic test_store();
        logic [31:0] addr [3] = '{32'h100, 32'h103, 32'h102};
        logic [31:0] data [3] = '{32'hDEADBEEF, 32'h000000AB, 32'h00001234};
        logic [2:0]  f3   [3] = '{F3_SW, F3_SB, F3_SH};
        logic [3:0]  ebe  [3] = '{4'b1111, 4'b1000, 4'b1100};
        logic [31:0] ewd  [3] = '{32'hDEADBEEF, 32'hABABABAB, 32'h12341234};
        for (int i = 0; i < 3; i++) begin
            ex_store(addr[i], data[i], f3[i]);
            step();
            ex_nop();
            mem_gnt_i = 1'b1;
            #2;
            vectors++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1) begin miscompares++; $display("FAIL store%0d_req got req %b we %b exp 1 1", i, mem_req_o, mem_we_o); end
            vectors++; if (mem_addr_o !== 32'h100) begin miscompares++; $display("FAIL store%0d_addr got %h exp %h", i, mem_addr_o, 32'h100); end
            vectors++; if (mem_be_o !== ebe[i]) begin miscompares++; $display("FAIL store%0d_be got %b exp %b", i, mem_be_o, ebe[i]); end
            vectors++; if (mem_wdata_o !== ewd[i]) begin miscompares++; $display("FAIL store%0d_wdata got %h exp %h", i, mem_wdata_o, ewd[i]); end
            vectors++; if (stall_M !== 1'b0) begin miscompares++; $display("FAIL store%0d_stall got %b exp 0", i, stall_M); end
            step();
            mem_gnt_i = 1'b0;
            #2;
            vectors++; if (mem_req_o !== 1'b0 || stall_M !== 1'b0) begin miscompares++; $display("FAIL store%0d_after got req %b stall %b exp 0 0", i, mem_req_o, stall_M); end
            $display("store %0d: addr %h be %b wdata %h", i, addr[i], mem_be_o, ewd[i]);
        end
    endtask

    // Load with gnt held off for gnt_delay cycles and rvalid one cycle after gnt.
    task automatic do_load(input string nm, input logic [31:0] addr, input logic [2:0] f3,
                           input int gnt_delay, input logic [31:0] rdata, input logic [31:0] exp_data);
        int stalls;
        stalls = 0;
        ex_load(addr, f3, 5'd5);
        step();
        ex_nop();
        for (int c = 0; c <= gnt_delay; c++) begin
            mem_gnt_i = (c == gnt_delay);
            #2;
            if (stall_M === 1'b1) stalls++;
            vectors++; if (mem_req_o !== 1'b1) begin miscompares++; $display("FAIL %s_req_c%0d got %b exp 1", nm, c, mem_req_o); end
            step();
        end
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = rdata;
        #2;
        vectors++; if (mem_req_o !== 1'b0 || stall_M !== 1'b0) begin miscompares++; $display("FAIL %s_rv got req %b stall %b exp 0 0", nm, mem_req_o, stall_M); end
        vectors++; if (stalls != gnt_delay + 1) begin miscompares++; $display("FAIL %s_stall_cycles got %0d exp %0d", nm, stalls, gnt_delay + 1); end
        step();
        mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        #2;
        vectors++; if (load_data_W !== exp_data) begin miscompares++; $display("FAIL %s_data got %h exp %h", nm, load_data_W, exp_data); end
        vectors++; if (reg_write_W !== 1'b1 || mem_to_reg_W !== 1'b1 || rd_W !== 5'd5) begin miscompares++; $display("FAIL %s_wb got we %b m2r %b rd %0d exp 1 1 5", nm, reg_write_W, mem_to_reg_W, rd_W); end
        $display("load %s: addr %h rdata %h -> %h", nm, addr, rdata, exp_data);
    endtask

    task automatic test_load();
        do_load("lb",  32'h102, F3_LB,  2, 32'h12803456, 32'hFFFFFF80);
        do_load("lbu", 32'h102, F3_LBU, 0, 32'h12803456, 32'h00000080);
        do_load("lh",  32'h102, F3_LH,  1, 32'h9ABC0000, 32'hFFFF9ABC);
        do_load("lw",  32'h104, F3_LW,  0, 32'hCAFEF00D, 32'hCAFEF00D);
    endtask

    task automatic test_misalign();
        ex_load(32'h101, F3_LW, 5'd7);
        step();
        ex_nop();
        mem_gnt_i = 1'b1;
        #2;
        vectors++; if (misalign_M !== 1'b1) begin miscompares++; $display("FAIL mis_pulse got %b exp 1", misalign_M); end
        vectors++; if (mem_req_o !== 1'b0 || stall_M !== 1'b0) begin miscompares++; $display("FAIL mis_req got req %b stall %b exp 0 0", mem_req_o, stall_M); end
        step();
        mem_gnt_i = 1'b0;
        #2;
        vectors++; if (misalign_M !== 1'b0) begin miscompares++; $display("FAIL mis_one_cycle got %b exp 0", misalign_M); end
        vectors++; if (reg_write_W !== 1'b0 || rd_W !== 5'd7) begin miscompares++; $display("FAIL mis_retire got we %b rd %0d exp 0 7", reg_write_W, rd_W); end
        $display("misalign: LW 0x101 retired without request");
    endtask

    task automatic test_reset_mid_access();
        ex_load(32'h200, F3_LW, 5'd4);
        step();
        ex_nop();
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFFFFFF;
        #2;
        vectors++; if (mem_req_o !== 1'b0 || stall_M !== 1'b0) begin miscompares++; $display("FAIL rstmid_req got req %b stall %b exp 0 0", mem_req_o, stall_M); end
        vectors++; if (alu_data_M !== 32'h0 || rd_M !== 5'd0 || reg_write_M !== 1'b0) begin miscompares++; $display("FAIL rstmid_m got alu %h rd %0d we %b exp 0", alu_data_M, rd_M, reg_write_M); end
        step();
        mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        #2;
        vectors++; if (load_data_W !== 32'h0 || reg_write_W !== 1'b0 || mem_to_reg_W !== 1'b0) begin miscompares++; $display("FAIL rstmid_stray got data %h we %b m2r %b exp 0", load_data_W, reg_write_W, mem_to_reg_W); end
        $display("reset mid-access: stray rvalid ignored");
    endtask

    task automatic test_back_to_back();
        ex_load(32'h300, F3_LW, 5'd3);
        step();
        ex_nop();
        alu_data_E = 32'h55; rd_E = 5'd9; reg_write_E = 1'b1;
        mem_gnt_i = 1'b1;
        #2;
        vectors++; if (stall_M !== 1'b1 || alu_data_M !== 32'h300 || rd_M !== 5'd3) begin miscompares++; $display("FAIL b2b_c0 got stall %b alu %h rd %0d exp 1 300 3", stall_M, alu_data_M, rd_M); end
        step();
        mem_gnt_i = 1'b0;
        #2;
        vectors++; if (stall_M !== 1'b1 || alu_data_M !== 32'h300 || rd_M !== 5'd3) begin miscompares++; $display("FAIL b2b_hold got stall %b alu %h rd %0d exp 1 300 3", stall_M, alu_data_M, rd_M); end
        vectors++; if (reg_write_W !== 1'b0 || mem_to_reg_W !== 1'b0) begin miscompares++; $display("FAIL b2b_bubble1 got %b%b exp 00", reg_write_W, mem_to_reg_W); end
        step();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
        #2;
        vectors++; if (stall_M !== 1'b0) begin miscompares++; $display("FAIL b2b_done got stall %b exp 0", stall_M); end
        vectors++; if (reg_write_W !== 1'b0 || mem_to_reg_W !== 1'b0) begin miscompares++; $display("FAIL b2b_bubble2 got %b%b exp 00", reg_write_W, mem_to_reg_W); end
        step();
        mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        ex_nop();
        #2;
        vectors++; if (alu_data_M !== 32'h55 || rd_M !== 5'd9) begin miscompares++; $display("FAIL b2b_ex_capture got alu %h rd %0d exp 55 9", alu_data_M, rd_M); end
        vectors++; if (load_data_W !== 32'hCAFEF00D || rd_W !== 5'd3 || reg_write_W !== 1'b1 || mem_to_reg_W !== 1'b1) begin miscompares++; $display("FAIL b2b_load_wb got data %h rd %0d we %b m2r %b exp cafef00d 3 1 1", load_data_W, rd_W, reg_write_W, mem_to_reg_W); end
        step();
        #2;
        vectors++; if (alu_data_W !== 32'h55 || rd_W !== 5'd9 || reg_write_W !== 1'b1 || mem_to_reg_W !== 1'b0) begin miscompares++; $display("FAIL b2b_alu_wb got alu %h rd %0d we %b m2r %b exp 55 9 1 0", alu_data_W, rd_W, reg_write_W, mem_to_reg_W); end
        $display("back-to-back: load stalled 2 cycles, ALU op followed");
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_misalign();
        test_reset_mid_access();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
